cla_sub_pipe: RTL

CLA_SUB_PIPE -- requirements
Module: cla_sub_pipe

---
 rtl/adder_pkg.sv | 13 +
 rtl/cla_slice.sv | 44 ++++
 rtl/cla_sub_pipe.sv | 103 ++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared constants for the pipelined carry-lookahead add/subtract unit.
// Operation encoding is the value driven on i_sub.
package adder_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STAGES = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/cla_slice.sv
// Combinational SW-bit carry-lookahead slice. b_i arrives already
// conditioned (inverted for subtraction) by the caller.
module cla_slice #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a_i,
    input  logic [SW-1:0] b_i,
    input  logic          cin_i,
    output logic [SW-1:0] sum_o,
    output logic          cout_o
);

    logic [SW-1:0] gen;
    logic [SW-1:0] prop;
    logic [SW:0]   carry;
    logic          term;
    logic          run;

    assign gen  = a_i & b_i;
    assign prop = a_i | b_i;

    // Each carry is the flat OR of generate terms gated by the running propagate
    // product, so no carry depends on the previously computed one.
    always_comb begin
        carry    = '0;
        term     = 1'b0;
        run      = 1'b0;
        carry[0] = cin_i;
        for (int i = 0; i < SW; i++) begin
            term = gen[i];
            run  = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (run & gen[j]);
                run  = run & prop[j];
            end
            term         = term | (run & cin_i);
            carry[i + 1] = term;
        end
    end

    assign sum_o  = a_i ^ b_i ^ carry[SW-1:0];
    assign cout_o = carry[SW];

endmodule

// File: rtl/cla_sub_pipe.sv
// Pipelined add/subtract: slice k of the operands is resolved in stage k, with
// the slice carry registered into the next stage and a single global stall.
module cla_sub_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_flag
);

    // WIDTH must be a multiple of STAGES.
    localparam int               SW   = WIDTH / STAGES;
    localparam logic [WIDTH-1:0] ONES = '1;

    logic              advance;
    logic [STAGES-1:0] valid_q, sub_q, carry_q, carry_d;
    logic [STAGES-1:0] srcValid, srcSub, srcCin;
    logic [WIDTH-1:0]  opA_q  [STAGES];
    logic [WIDTH-1:0]  opB_q  [STAGES];
    logic [WIDTH-1:0]  res_q  [STAGES];
    logic [WIDTH-1:0]  res_d  [STAGES];
    logic [WIDTH-1:0]  srcA   [STAGES];
    logic [WIDTH-1:0]  srcB   [STAGES];
    logic [WIDTH-1:0]  srcRes [STAGES];
    logic [SW-1:0]     sliceSum [STAGES];
    logic              unusedOps;

    assign advance = ~valid_q[STAGES-1] | i_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] MASK = (ONES >> (WIDTH - SW)) << (k * SW);

        if (k == 0) begin : g_first
            assign srcValid[k] = i_valid;
            assign srcSub[k]   = i_sub;
            assign srcCin[k]   = i_sub;
            assign srcA[k]     = i_op1;
            assign srcB[k]     = i_op2;
            assign srcRes[k]   = '0;
        end else begin : g_next
            assign srcValid[k] = valid_q[k-1];
            assign srcSub[k]   = sub_q[k-1];
            assign srcCin[k]   = carry_q[k-1];
            assign srcA[k]     = opA_q[k-1];
            assign srcB[k]     = opB_q[k-1];
            assign srcRes[k]   = res_q[k-1];
        end

        cla_slice #(
            .SW(SW)
        ) u_slice (
            .a_i    (srcA[k][k*SW +: SW]),
            .b_i    (srcB[k][k*SW +: SW] ^ {SW{srcSub[k]}}),
            .cin_i  (srcCin[k]),
            .sum_o  (sliceSum[k]),
            .cout_o (carry_d[k])
        );

        assign res_d[k] = (srcRes[k] & ~MASK) | (WIDTH'(sliceSum[k]) << (k * SW));
    end

    // Every stage loads together; a held output freezes the whole pipe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= '0;
            sub_q   <= '0;
            carry_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                opA_q[k] <= '0;
                opB_q[k] <= '0;
                res_q[k] <= '0;
            end
        end else if (advance) begin
            valid_q <= srcValid;
            sub_q   <= srcSub;
            carry_q <= carry_d;
            for (int k = 0; k < STAGES; k++) begin
                opA_q[k] <= srcA[k];
                opB_q[k] <= srcB[k];
                res_q[k] <= res_d[k];
            end
        end
    end

    assign unusedOps = ^{opA_q[STAGES-1], opB_q[STAGES-1]};

    assign o_ready  = advance;
    assign o_valid  = valid_q[STAGES-1];
    assign o_result = res_q[STAGES-1];
    assign o_flag   = (sub_q[STAGES-1] == OP_SUB) ? ~carry_q[STAGES-1] : carry_q[STAGES-1];

endmodule
